// File: rtl/noc_collector_pkg.sv
// Shared defaults, FSM encoding and flit field helpers for the NoC collector.
`ifndef NOC_COLLECTOR_PKG_SV
`define NOC_COLLECTOR_PKG_SV

// Flit layout: {pid, src, ts}, packed against bit 0.
`define NOC_PID(f, PW, SW, TW) f[(PW)+(SW)+(TW)-1 -: (PW)]
`define NOC_SRC(f, SW, TW)     f[(SW)+(TW)-1 -: (SW)]
`define NOC_TS(f, TW)          f[(TW)-1:0]

package noc_collector_pkg;

  localparam int PID_W_DEF = 10;
  localparam int SRC_W_DEF = 6;
  localparam int TS_W_DEF  = 16;

  typedef enum logic {
    WAIT_REQ = 1'b0,
    GRANT    = 1'b1
  } collectorState_e;

  function automatic logic [31:0] satAdd32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

`endif

// File: rtl/collector_fifo.sv
// First-word fall-through record FIFO with occupancy count and registered full flag.
module collector_fifo
  import noc_collector_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         popData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;
  logic [CW-1:0]    countNext;

  // A pop in the same cycle frees the slot, so a push is legal even when full.
  assign doPop  = pop & (count != '0);
  assign doPush = push & ((count != CW'(DEPTH)) | doPop);

  always_comb begin
    countNext = count;
    if (doPush && !doPop) begin
      countNext = count + CW'(1);
    end else if (doPop && !doPush) begin
      countNext = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      count <= countNext;
      full  <= (countNext == CW'(DEPTH));
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  assign valid   = (count != '0);
  assign popData = mem[rdPtr];

endmodule

// File: rtl/noc_collector_fifo.sv
// Packet sink at a router Local port: Req/Gnt intake, latency stamping, record FIFO and stats.
module noc_collector_fifo
  import noc_collector_pkg::*;
#(
  parameter logic [5:0] MODULE_ID = 6'd0,
  parameter int PID_W  = PID_W_DEF,
  parameter int SRC_W  = SRC_W_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int LOG_EN = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            PacketIn,
  input  logic                         ReqUpStr,
  output logic                         GntUpStr,
  output logic                         UpStrFull,
  output logic                         rec_valid,
  input  logic                         rec_ready,
  output logic [PID_W+SRC_W+TS_W-1:0]  rec_data,
  input  logic                         stats_clr,
  output logic [31:0]                  rx_count,
  output logic [TS_W-1:0]              lat_max,
  output logic [31:0]                  lat_sum,
  output logic [31:0]                  cycle_cnt,
  output logic                         dbgState
);

  localparam int CW = $clog2(DEPTH) + 1;

  collectorState_e state;
  collectorState_e stateNext;
  logic            accept;
  logic [CW-1:0]   fifoCount;

  logic [PID_W-1:0] pid;
  logic [SRC_W-1:0] src;
  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  latency;

  logic [31:0]      cycleCnt;
  logic [31:0]      rxCount;
  logic [31:0]      latSum;
  logic [TS_W-1:0]  latMax;

  assign pid = `NOC_PID(PacketIn, PID_W, SRC_W, TS_W);
  assign src = `NOC_SRC(PacketIn, SRC_W, TS_W);
  assign ts  = `NOC_TS(PacketIn, TS_W);

  // Modulo subtraction: a timestamp taken just before the counter wrapped still yields a small latency.
  assign latency = cycleCnt[TS_W-1:0] - ts;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WAIT_REQ;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      WAIT_REQ: begin
        if (ReqUpStr && (fifoCount < CW'(DEPTH))) begin
          accept    = 1'b1;
          stateNext = GRANT;
        end
      end
      GRANT: begin
        stateNext = WAIT_REQ;
      end
    endcase
  end

  // The grant pulse is exactly the cycle spent in GRANT.
  assign GntUpStr = (state == GRANT);
  assign dbgState = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycleCnt <= '0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
    end
  end

  // A clear coinciding with a push restarts the statistics from that packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxCount <= '0;
      latSum  <= '0;
      latMax  <= '0;
    end else if (stats_clr) begin
      rxCount <= accept ? 32'd1 : 32'd0;
      latSum  <= accept ? 32'(latency) : 32'd0;
      latMax  <= accept ? latency : '0;
    end else if (accept) begin
      if (rxCount != 32'hFFFF_FFFF) rxCount <= rxCount + 32'd1;
      latSum <= satAdd32(latSum, 32'(latency));
      if (latency > latMax) latMax <= latency;
    end
  end

  collector_fifo #(
    .WIDTH (PID_W + SRC_W + TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .pushData ({pid, src, latency}),
    .pop      (rec_ready),
    .valid    (rec_valid),
    .popData  (rec_data),
    .count    (fifoCount),
    .full     (UpStrFull)
  );

  assign rx_count  = rxCount;
  assign lat_max   = latMax;
  assign lat_sum   = latSum;
  assign cycle_cnt = cycleCnt;

`ifndef SYNTHESIS
  if (LOG_EN != 0) begin : gLog
    always_ff @(posedge clk) begin
      if (reset && accept) begin
        $display("collector %0d: pid=%0d src=%0d latency=%0d",
                 MODULE_ID, pid, src, latency);
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_collector_fifo.sv
// Directed bench for noc_collector_fifo: vector table plus hand-written handshake sequences.
module tb_noc_collector_fifo;

  localparam int PID_W  = 10;
  localparam int SRC_W  = 6;
  localparam int TS_W   = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int REC_W  = PID_W + SRC_W + TS_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] PacketIn = '0;
  logic              ReqUpStr = 1'b0;
  logic              GntUpStr;
  logic              UpStrFull;
  logic              rec_valid;
  logic              rec_ready = 1'b0;
  logic [REC_W-1:0]  rec_data;
  logic              stats_clr = 1'b0;
  logic [31:0]       rx_count;
  logic [TS_W-1:0]   lat_max;
  logic [31:0]       lat_sum;
  logic [31:0]       cycle_cnt;
  logic              dbgState;

  noc_collector_fifo #(
    .MODULE_ID (6'd0),
    .PID_W     (PID_W),
    .SRC_W     (SRC_W),
    .TS_W      (TS_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .LOG_EN    (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .PacketIn  (PacketIn),
    .ReqUpStr  (ReqUpStr),
    .GntUpStr  (GntUpStr),
    .UpStrFull (UpStrFull),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_data  (rec_data),
    .stats_clr (stats_clr),
    .rx_count  (rx_count),
    .lat_max   (lat_max),
    .lat_sum   (lat_sum),
    .cycle_cnt (cycle_cnt),
    .dbgState  (dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Independent model of the cycle counter.
  int unsigned tbCycle;
  always @(posedge clk or negedge reset) begin
    if (!reset) tbCycle <= 0;
    else        tbCycle <= tbCycle + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total  = 0;
  logic [REC_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Inputs are final for the coming edge here, so a pop decided now is the one the DUT performs.
  task automatic nextCycle();
    if (reset && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_pop", 64'(exp_q.size()), 1);
      else check("sb_rec_data", rec_data, exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  // ---------------- driver ----------------
  task automatic sendPkt(input logic [PID_W-1:0] pid, input logic [SRC_W-1:0] src,
                         input logic [TS_W-1:0] ts, input int maxWait, output bit got);
    logic [TS_W-1:0] lat;
    PacketIn = {pid, src, ts};
    ReqUpStr = 1'b1;
    got = 1'b0;
    for (int i = 0; i < maxWait && !got; i++) begin
      nextCycle();
      if (GntUpStr) got = 1'b1;
    end
    if (got) begin
      lat = TS_W'(tbCycle - 1) - ts;
      exp_q.push_back({pid, src, lat});
    end
    ReqUpStr = 1'b0;
    nextCycle();
  endtask

  typedef struct {
    logic [PID_W-1:0] pid;
    logic [SRC_W-1:0] src;
    logic [TS_W-1:0]  lat;
    logic [31:0]      expRx;
    logic [TS_W-1:0]  expMax;
    logic [31:0]      expSum;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit got;
    bit gotAny;
    logic [TS_W-1:0] ts9;
    logic [TS_W-1:0] ts5;

    vecs[0] = '{pid: 10'd1, src: 6'd3,  lat: 16'd4,   expRx: 32'd1, expMax: 16'd4,   expSum: 32'd4};
    vecs[1] = '{pid: 10'd2, src: 6'd5,  lat: 16'd20,  expRx: 32'd2, expMax: 16'd20,  expSum: 32'd24};
    vecs[2] = '{pid: 10'd3, src: 6'd0,  lat: 16'd0,   expRx: 32'd3, expMax: 16'd20,  expSum: 32'd24};
    vecs[3] = '{pid: 10'd4, src: 6'd63, lat: 16'd100, expRx: 32'd4, expMax: 16'd100, expSum: 32'd124};
    vecs[4] = '{pid: 10'd5, src: 6'd1,  lat: 16'd9,   expRx: 32'd5, expMax: 16'd100, expSum: 32'd133};

    // Reset state
    nextCycle();
    nextCycle();
    check("rst_gnt", GntUpStr, 0);
    check("rst_full", UpStrFull, 0);
    check("rst_valid", rec_valid, 0);
    check("rst_rx", rx_count, 0);
    check("rst_lat_max", lat_max, 0);
    check("rst_lat_sum", lat_sum, 0);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_state", dbgState, 0);
    reset = 1'b1;

    // Single packet at cycle 10
    for (int i = 0; i < 20 && tbCycle != 10; i++) nextCycle();
    check("t1_cycle_at_req", cycle_cnt, 10);
    PacketIn = {10'd5, 6'o12, 16'd3};
    ReqUpStr = 1'b1;
    nextCycle();
    check("t1_gnt", GntUpStr, 1);
    check("t1_state_grant", dbgState, 1);
    check("t1_valid", rec_valid, 1);
    check("t1_rec_data", rec_data, 32'h014A_0007);
    check("t1_rx", rx_count, 1);
    check("t1_lat_max", lat_max, 7);
    check("t1_lat_sum", lat_sum, 7);
    exp_q.push_back(32'h014A_0007);
    ReqUpStr = 1'b0;
    nextCycle();
    check("t1_gnt_pulse_end", GntUpStr, 0);
    check("t1_state_wait", dbgState, 0);
    rec_ready = 1'b1;
    nextCycle();
    rec_ready = 1'b0;
    check("t1_popped", rec_valid, 0);
    stats_clr = 1'b1;
    nextCycle();
    stats_clr = 1'b0;
    check("clr_rx", rx_count, 0);
    check("clr_lat_max", lat_max, 0);
    check("clr_lat_sum", lat_sum, 0);

    // Vector table: accumulated statistics
    for (int i = 0; i < 5; i++) begin
      sendPkt(vecs[i].pid, vecs[i].src, TS_W'(tbCycle) - vecs[i].lat, 6, got);
      check($sformatf("vec%0d_gnt", i), got, 1);
      check($sformatf("vec%0d_rx", i), rx_count, vecs[i].expRx);
      check($sformatf("vec%0d_lat_max", i), lat_max, vecs[i].expMax);
      check($sformatf("vec%0d_lat_sum", i), lat_sum, vecs[i].expSum);
    end

    // Clear coinciding with a push of latency 9
    ts5 = TS_W'(tbCycle - 9);
    PacketIn = {10'd40, 6'd33, ts5};
    ReqUpStr = 1'b1;
    stats_clr = 1'b1;
    nextCycle();
    stats_clr = 1'b0;
    check("t5_gnt", GntUpStr, 1);
    check("t5_rx", rx_count, 1);
    check("t5_lat_sum", lat_sum, 9);
    check("t5_lat_max", lat_max, 9);
    if (GntUpStr) exp_q.push_back({10'd40, 6'd33, 16'd9});
    ReqUpStr = 1'b0;
    nextCycle();

    rec_ready = 1'b1;
    for (int i = 0; i < 20 && rec_valid; i++) nextCycle();
    rec_ready = 1'b0;
    check("drain1_sb_empty", 64'(exp_q.size()), 0);
    check("drain1_valid", rec_valid, 0);

    // Fill to DEPTH, then a ninth request is held off
    for (int i = 0; i < 8; i++) begin
      sendPkt(PID_W'(10 + i), SRC_W'(i), TS_W'(tbCycle), 6, got);
      check($sformatf("t2_gnt_%0d", i), got, 1);
      if (i == 6) check("t2_not_full_at_7", UpStrFull, 0);
    end
    check("t2_full_at_8", UpStrFull, 1);
    ts9 = TS_W'(tbCycle);
    PacketIn = {10'd18, 6'd8, ts9};
    ReqUpStr = 1'b1;
    gotAny = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      if (GntUpStr) gotAny = 1'b1;
    end
    check("t2_no_gnt_when_full", gotAny, 0);
    check("t2_state_hold", dbgState, 0);
    rec_ready = 1'b1;
    nextCycle();
    rec_ready = 1'b0;
    check("t2_full_falls", UpStrFull, 0);
    check("t2_no_gnt_at_pop", GntUpStr, 0);
    nextCycle();
    check("t2_ninth_gnt", GntUpStr, 1);
    if (GntUpStr) exp_q.push_back({10'd18, 6'd8, TS_W'(tbCycle - 1) - ts9});
    ReqUpStr = 1'b0;
    nextCycle();
    check("t2_full_again", UpStrFull, 1);

    // Streaming with simultaneous push and pop; order must hold
    rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sendPkt(PID_W'(19 + i), SRC_W'(20 + i), TS_W'(tbCycle), 6, got);
      check($sformatf("t4_gnt_%0d", i), got, 1);
      check($sformatf("t4_not_full_%0d", i), UpStrFull, 0);
    end
    for (int i = 0; i < 20 && rec_valid; i++) nextCycle();
    rec_ready = 1'b0;
    check("t4_sb_empty", 64'(exp_q.size()), 0);
    check("t4_valid", rec_valid, 0);

    // Reset while the grant is high
    sendPkt(10'd30, 6'd2, TS_W'(tbCycle), 6, got);
    check("t6_pre_gnt", got, 1);
    PacketIn = {10'd31, 6'd3, TS_W'(tbCycle)};
    ReqUpStr = 1'b1;
    nextCycle();
    check("t6_gnt_high", GntUpStr, 1);
    reset = 1'b0;
    #1;
    check("t6_gnt_dropped", GntUpStr, 0);
    check("t6_fifo_empty", rec_valid, 0);
    check("t6_full", UpStrFull, 0);
    check("t6_cycle", cycle_cnt, 0);
    check("t6_rx", rx_count, 0);
    check("t6_state", dbgState, 0);
    exp_q.delete();
    ReqUpStr = 1'b0;
    nextCycle();
    reset = 1'b1;

    // Timestamp wrap: ts=FFFE accepted at counter 3
    for (int i = 0; i < 10 && tbCycle != 3; i++) nextCycle();
    check("t3_cycle_at_req", cycle_cnt, 3);
    sendPkt(10'd50, 6'd7, 16'hFFFE, 6, got);
    check("t3_gnt", got, 1);
    check("t3_lat_field", rec_data[TS_W-1:0], 5);
    check("t3_lat_max", lat_max, 5);
    check("t3_lat_sum", lat_sum, 5);
    check("t3_rx", rx_count, 1);
    check("cycle_cnt_model", cycle_cnt, tbCycle);
    rec_ready = 1'b1;
    for (int i = 0; i < 10 && rec_valid; i++) nextCycle();
    rec_ready = 1'b0;
    check("t3_sb_empty", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
